mem_writeback: RTL
==================

// Module: mem_writeback
// PURPOSE
//  Y86-64 memory + write-back stage; consumer of execute results (valE, cnd) from the ALU/condition block.
//  Performs data-memory read/write over a req/ack handshake, then issues register write-back and the next PC.
//  Sequential, one instruction in flight; sticky halt on any non-AOK status.
// PARAMETERS
//  N           64    datapath width
//  MEM_BYTES   8192  data memory size in bytes; valid quad address: addr <= MEM_BYTES-8
//  MEM_TIMEOUT 15    max cycles in MEM waiting for mem_ack before declaring ADR
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  in_valid   in   1   execute result valid
//  in_ready   out  1   stage can accept (high only in IDLE)
//  icode      in   4   instruction code
//  cnd        in   1   condition from execute
//  valE       in   N   ALU result
//  valA       in   N   operand A (store data / pop,ret address)
//  valC       in   N   constant (jump target)
//  valP       in   N   fall-through PC
//  rA, rB     in   4   register ids; 4'hF = none
//  mem_req    out  1   memory request
//  mem_we     out  1   1 = write
//  mem_addr   out  N   byte address
//  mem_wdata  out  N   write data
//  mem_ack    in   1   request complete
//  mem_err    in   1   memory fault (valid with or without ack)
//  mem_rdata  in   N   read data, valid with mem_ack
//  wbE_en/wbE_reg/wbE_data  out 1/4/N  ALU-result write port
//  wbM_en/wbM_reg/wbM_data  out 1/4/N  memory-result write port
//  pc_valid   out  1   new_pc valid (1-cycle pulse)
//  new_pc     out  N   next PC
//  stat       out  2   00 AOK, 01 HLT, 10 ADR, 11 INS
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except in_ready=1; stat=AOK. Reset in any state aborts (no WB, no pc_valid); mem_req low the cycle after.
//  States: IDLE -> (accept: in_valid&in_ready; inputs registered) -> MEM if memory op and address in range, else WB.
//  MEM: mem_req=1, addr/we/wdata stable; mem_err -> stat ADR, go WB; mem_ack (no err) -> capture rdata, go WB; counter hits MEM_TIMEOUT -> ADR, go WB. err beats ack in same cycle.
//  WB: exactly one cycle; wb enables, pc_valid pulse; then IDLE if stat=AOK else HALT. HALT: in_ready=0, outputs idle, until reset.
//  Latency: non-memory op WB at accept+1; memory op WB at ack cycle+1.
//  Per icode: 0 halt: stat HLT, no writes, new_pc=valP | 1 nop: pc=valP | 2 cmov: wbE rB<-valE iff cnd | 3 irmovq, 6 opq: wbE rB<-valE
//   4 rmmovq: M[valE]<-valA | 5 mrmovq: wbM rA<-M[valE] | 7 jXX: pc = cnd ? valC : valP
//   8 call: M[valE]<-valP, wbE rsp<-valE, pc=valC | 9 ret: read M[valA], wbE rsp<-valE, pc=valM
//   A pushq: M[valE]<-valA, wbE rsp<-valE | B popq: read M[valA], wbE rsp<-valE, wbM rA<-valM | other: stat INS, no writes.
//  Non-jump/call/ret pc = valP. Address > MEM_BYTES-8 (unsigned): no request, stat ADR, straight to WB.
//  On non-AOK stat: all wb enables 0; pc_valid still pulses with new_pc=valP.
//  Reg id 4'hF suppresses that port. wbE_reg==wbM_reg with both enabled: wbM wins, wbE_en=0 (popq %rsp).
// STRUCTURE
//  Package y86_pkg: icode constants, STAT_* encodings, REG_RSP=4, REG_NONE=4'hF.
//  Sub-module mem_handshake: req hold, ack/err capture, timeout counter (width clog2(MEM_TIMEOUT+1)).
// TESTING
//  irmovq rB=2 valE=0x2A -> WB at accept+1: wbE_en=1 reg 2 data 0x2A, pc_valid, new_pc=valP, no mem_req.
//  mrmovq valE=0x100, ack 3 cycles later rdata=0xDEAD -> wbM rA data 0xDEAD at ack+1; mem_req held throughout.
//  popq rA=4 valA=0x1F8 valE=0x200 rdata=0x55 -> wbM_en reg4=0x55, wbE_en=0.
//  rmmovq valE=MEM_BYTES-4 -> no mem_req, stat ADR, then HALT: in_ready=0 until reset.
//  Memory never acks -> ADR after MEM_TIMEOUT cycles; separately ack+err same cycle -> ADR, no wbM.
//  Reset asserted mid-MEM -> mem_req low next cycle, no pc_valid, in_ready=1, stat AOK; cmov cnd=0 -> no wbE.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 memory/write-back stage:
// instruction codes, status codes, register ids and decode helpers.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_ADR = 2'b10,
        STAT_INS = 2'b11
    } stat_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_WB,
        S_HALT
    } wb_state_e;

    function automatic logic is_mem_op(input logic [3:0] ic);
        return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL,
                          I_RET, I_PUSHQ, I_POPQ};
    endfunction

    function automatic logic is_mem_write(input logic [3:0] ic);
        return ic inside {I_RMMOVQ, I_CALL, I_PUSHQ};
    endfunction

    // ret and popq read from the old stack pointer carried in valA
    function automatic logic addr_from_vala(input logic [3:0] ic);
        return ic inside {I_RET, I_POPQ};
    endfunction

    function automatic logic is_valid_icode(input logic [3:0] ic);
        return ic <= I_POPQ;
    endfunction

endpackage

// File: rtl/mem_handshake.sv
// Data-memory request/acknowledge handshake: holds the request until
// ack, error or timeout, captures read data and reports faults.
module mem_handshake #(
    parameter int N           = 64,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         we_i,
    input  logic [N-1:0] addr_i,
    input  logic [N-1:0] wdata_i,
    input  logic         mem_ack_i,
    input  logic         mem_err_i,
    input  logic [N-1:0] mem_rdata_i,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [N-1:0] mem_addr_o,
    output logic [N-1:0] mem_wdata_o,
    output logic         done_o,
    output logic         fault_o,
    output logic [N-1:0] rdata_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic          req_q;
    logic          we_q;
    logic [N-1:0]  addr_q;
    logic [N-1:0]  wdata_q;
    logic [N-1:0]  rdata_q;
    logic [CW-1:0] cnt_q;
    logic          timeout;

    // The last allowed waiting cycle ends the request; a late ack still wins.
    assign timeout = req_q && !mem_ack_i && !mem_err_i && (cnt_q == LAST);
    assign done_o  = req_q && (mem_ack_i || mem_err_i || timeout);
    assign fault_o = req_q && (mem_err_i || timeout);

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

    // Request hold, read-data capture and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else if (start_i) begin
            req_q   <= 1'b1;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= '0;
        end else if (done_o) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            if (mem_ack_i && !mem_err_i) begin
                rdata_q <= mem_rdata_i;
            end
        end else if (req_q) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mem_writeback.sv
// Y86-64 memory + write-back stage: one instruction in flight,
// memory access over req/ack, then register write-back and next PC.
module mem_writeback
    import y86_pkg::*;
#(
    parameter int N           = 64,
    parameter int MEM_BYTES   = 8192,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic         cnd,
    input  logic [N-1:0] valE,
    input  logic [N-1:0] valA,
    input  logic [N-1:0] valC,
    input  logic [N-1:0] valP,
    input  logic [3:0]   rA,
    input  logic [3:0]   rB,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic         mem_err,
    input  logic [N-1:0] mem_rdata,
    output logic         wbE_en,
    output logic [3:0]   wbE_reg,
    output logic [N-1:0] wbE_data,
    output logic         wbM_en,
    output logic [3:0]   wbM_reg,
    output logic [N-1:0] wbM_data,
    output logic         pc_valid,
    output logic [N-1:0] new_pc,
    output logic [1:0]   stat
);

    localparam logic [N-1:0] ADDR_MAX = N'(MEM_BYTES - 8);

    wb_state_e    state_q, state_d;
    stat_e        stat_q, stat_d;
    logic [3:0]   icode_q, rA_q, rB_q;
    logic         cnd_q;
    logic [N-1:0] valE_q, valA_q, valC_q, valP_q;

    logic         accept;
    logic         mem_start;
    logic         hs_done;
    logic         hs_fault;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;
    logic [N-1:0] valM;

    logic         e_en, m_en;
    logic [3:0]   e_reg, m_reg;
    logic [N-1:0] pc_sel;

    assign in_ready  = (state_q == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign req_addr  = addr_from_vala(icode) ? valA : valE;
    assign req_wdata = (icode == I_CALL) ? valP : valA;
    assign stat      = stat_q;

    mem_handshake #(
        .N           (N),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_hs (
        .clk         (clk),
        .reset       (reset),
        .start_i     (mem_start),
        .we_i        (is_mem_write(icode)),
        .addr_i      (req_addr),
        .wdata_i     (req_wdata),
        .mem_ack_i   (mem_ack),
        .mem_err_i   (mem_err),
        .mem_rdata_i (mem_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .done_o      (hs_done),
        .fault_o     (hs_fault),
        .rdata_o     (valM)
    );

    // State, sticky status and the accepted instruction's fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= '0;
            cnd_q   <= 1'b0;
            rA_q    <= '0;
            rB_q    <= '0;
            valE_q  <= '0;
            valA_q  <= '0;
            valC_q  <= '0;
            valP_q  <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            if (accept) begin
                icode_q <= icode;
                cnd_q   <= cnd;
                rA_q    <= rA;
                rB_q    <= rB;
                valE_q  <= valE;
                valA_q  <= valA;
                valC_q  <= valC;
                valP_q  <= valP;
            end
        end
    end

    // Next state and status; bad opcodes and addresses skip memory
    always_comb begin
        state_d   = state_q;
        stat_d    = stat_q;
        mem_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WB;
                    if (icode == I_HALT) begin
                        stat_d = STAT_HLT;
                    end else if (!is_valid_icode(icode)) begin
                        stat_d = STAT_INS;
                    end else if (is_mem_op(icode)) begin
                        if (req_addr > ADDR_MAX) begin
                            stat_d = STAT_ADR;
                        end else begin
                            state_d   = S_MEM;
                            mem_start = 1'b1;
                        end
                    end
                end
            end
            S_MEM: begin
                if (hs_done) begin
                    state_d = S_WB;
                    if (hs_fault) begin
                        stat_d = STAT_ADR;
                    end
                end
            end
            S_WB: begin
                state_d = (stat_q == STAT_AOK) ? S_IDLE : S_HALT;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Per-instruction write-back ports and next PC
    always_comb begin
        e_en   = 1'b0;
        e_reg  = rB_q;
        m_en   = 1'b0;
        m_reg  = rA_q;
        pc_sel = valP_q;
        unique case (icode_q)
            I_CMOVXX: e_en = cnd_q;
            I_IRMOVQ,
            I_OPQ:    e_en = 1'b1;
            I_MRMOVQ: m_en = 1'b1;
            I_JXX: begin
                if (cnd_q) begin
                    pc_sel = valC_q;
                end
            end
            I_CALL: begin
                e_en   = 1'b1;
                e_reg  = REG_RSP;
                pc_sel = valC_q;
            end
            I_RET: begin
                e_en   = 1'b1;
                e_reg  = REG_RSP;
                pc_sel = valM;
            end
            I_PUSHQ: begin
                e_en  = 1'b1;
                e_reg = REG_RSP;
            end
            I_POPQ: begin
                e_en  = 1'b1;
                e_reg = REG_RSP;
                m_en  = 1'b1;
            end
            default: begin
                e_en = 1'b0;
            end
        endcase
    end

    // Write-back outputs, live only during the single WB cycle
    always_comb begin
        wbE_en   = 1'b0;
        wbE_reg  = '0;
        wbE_data = '0;
        wbM_en   = 1'b0;
        wbM_reg  = '0;
        wbM_data = '0;
        pc_valid = 1'b0;
        new_pc   = '0;
        if (state_q == S_WB) begin
            pc_valid = 1'b1;
            new_pc   = valP_q;
            if (stat_q == STAT_AOK) begin
                new_pc = pc_sel;
                wbM_en = m_en && (m_reg != REG_NONE);
                // popq %rsp: the loaded value wins over the increment
                wbE_en = e_en && (e_reg != REG_NONE)
                         && !(wbM_en && (m_reg == e_reg));
                if (wbM_en) begin
                    wbM_reg  = m_reg;
                    wbM_data = valM;
                end
                if (wbE_en) begin
                    wbE_reg  = e_reg;
                    wbE_data = valE_q;
                end
            end
        end
    end

endmodule
